// File: rtl/temp_report_tx_pkg.sv
// Shared ASCII codes, FSM state types and the report character mux for temp_report_tx.
package temp_report_tx_pkg;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_DOT   = 8'h2E;
   localparam logic [7:0] ASCII_S     = 8'h53;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_A     = 8'h41;

   localparam logic [3:0] LastIdx = 4'd9;

   typedef enum logic [1:0] {StByteIdle, StByteStart, StByteData, StByteStop} byte_state_e;
   typedef enum logic {StIdle, StSend} report_state_e;

   typedef struct packed {
      logic       mode;
      logic [5:0] temp;
      logic [3:0] frac;
      logic [3:0] state;
   } report_fields_t;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return ASCII_0 + {4'd0, d};
   endfunction

   function automatic logic [7:0] report_char(input logic [3:0] idx, input report_fields_t f);
      logic [3:0] tens;
      logic [3:0] ones;
      logic [3:0] frac_c;
      logic [7:0] c;
      tens   = 4'(f.temp / 6'd10);
      ones   = 4'(f.temp % 6'd10);
      frac_c = (f.frac > 4'd9) ? 4'd9 : f.frac;
      case (idx)
         4'd0:    c = f.mode ? ASCII_MINUS : ASCII_SPACE;
         4'd1:    c = digit_char(tens);
         4'd2:    c = digit_char(ones);
         4'd3:    c = ASCII_DOT;
         4'd4:    c = digit_char(frac_c);
         4'd5:    c = ASCII_SPACE;
         4'd6:    c = ASCII_S;
         4'd7:    c = (f.state < 4'd10) ? digit_char(f.state)
                                        : ASCII_A + {4'd0, f.state - 4'd10};
         4'd8:    c = ASCII_CR;
         default: c = ASCII_LF;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte shifter; done pulses combinationally in the last stop-bit cycle so that a
// load in that same cycle starts the next byte with no idle gap.
module uart_tx_byte
   import temp_report_tx_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);

   localparam int unsigned CntW = $clog2(BAUD_DIV);
   localparam logic [CntW-1:0] CntLast = CntW'(BAUD_DIV - 1);

   byte_state_e     state_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      bit_q;
   logic [7:0]      shreg_q;
   logic            tx_q;
   logic            bit_end;

   assign bit_end = (cnt_q == CntLast);
   assign done    = (state_q == StByteStop) && bit_end;
   assign tx      = tx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StByteIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
      end else if (load) begin
         state_q <= StByteStart;
         cnt_q   <= '0;
         shreg_q <= data;
         tx_q    <= 1'b0;
      end else if (state_q != StByteIdle) begin
         if (!bit_end) begin
            cnt_q <= cnt_q + 1'b1;
         end else begin
            cnt_q <= '0;
            unique case (state_q)
               StByteStart: begin
                  state_q <= StByteData;
                  bit_q   <= '0;
                  tx_q    <= shreg_q[0];
               end
               StByteData: begin
                  if (bit_q == 3'd7) begin
                     state_q <= StByteStop;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     shreg_q <= {1'b0, shreg_q[7:1]};
                     tx_q    <= shreg_q[1];
                  end
               end
               StByteStop: begin
                  state_q <= StByteIdle;
                  tx_q    <= 1'b1;
               end
               default: state_q <= StByteIdle;
            endcase
         end
      end
   end

endmodule

// File: rtl/temp_report_tx.sv
// Formats temperature and monitor state as a 10-character ASCII line and sends it over 8N1.
// The byte-select step runs in the shifter's done cycle, so bytes go out back to back.
module temp_report_tx
   import temp_report_tx_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned BAUD     = 115_200,
   parameter int unsigned BAUD_DIV = (CLK_HZ + BAUD / 2) / BAUD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       mode,
   input  logic [5:0] temp,
   input  logic [3:0] temp_frac,
   input  logic [3:0] state,
   output logic       tx,
   output logic       busy
);

   report_state_e  state_q;
   logic [3:0]     idx_q;
   report_fields_t snap_q;
   logic           busy_q;

   report_fields_t live_fields;
   logic           byte_done;
   logic           last_done;
   logic           next_byte;
   logic           accept;
   logic           byte_load;
   logic [7:0]     byte_data;

   assign live_fields = '{mode: mode, temp: temp, frac: temp_frac, state: state};

   assign last_done = (state_q == StSend) && byte_done && (idx_q == LastIdx);
   assign next_byte = (state_q == StSend) && byte_done && (idx_q != LastIdx);
   // A start arriving in the final done cycle is accepted immediately.
   assign accept    = start && ((state_q == StIdle) || last_done);
   assign byte_load = accept || next_byte;
   assign byte_data = accept ? report_char(4'd0, live_fields)
                             : report_char(idx_q + 4'd1, snap_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         snap_q  <= '0;
         busy_q  <= 1'b0;
      end else if (accept) begin
         state_q <= StSend;
         idx_q   <= '0;
         snap_q  <= live_fields;
         busy_q  <= 1'b1;
      end else if (next_byte) begin
         idx_q <= idx_q + 4'd1;
      end else if (last_done) begin
         state_q <= StIdle;
         idx_q   <= '0;
         busy_q  <= 1'b0;
      end
   end

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_uart_tx_byte (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (byte_load),
      .data  (byte_data),
      .tx    (tx),
      .done  (byte_done)
   );

   assign busy = busy_q;

endmodule

// File: tb/tb_temp_report_tx.sv
// Scoreboard bench for temp_report_tx: expected bytes are queued at start and checked by a
// mid-bit sampling UART receiver.
module tb_temp_report_tx;

   localparam int unsigned Div = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic [5:0] temp = '0;
   logic [3:0] temp_frac = '0;
   logic [3:0] state = '0;
   logic       tx;
   logic       busy;

   int n_vectors = 0;
   int n_miscompares = 0;
   int busy_cycles = 0;
   int tx_low_cycles = 0;
   int rx_bytes = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   temp_report_tx #(
      .CLK_HZ   (1_000_000),
      .BAUD     (100_000),
      .BAUD_DIV (Div)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .temp      (temp),
      .temp_frac (temp_frac),
      .state     (state),
      .tx        (tx),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vectors++;
      if (obs !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_char(input int idx, input int m, input int t,
                                             input int f, input int s);
      case (idx)
         0:       return (m != 0) ? 8'h2D : 8'h20;
         1:       return 8'(48 + t / 10);
         2:       return 8'(48 + t % 10);
         3:       return 8'h2E;
         4:       return 8'(48 + ((f > 9) ? 9 : f));
         5:       return 8'h20;
         6:       return 8'h53;
         7:       return (s < 10) ? 8'(48 + s) : 8'(65 + s - 10);
         8:       return 8'h0D;
         default: return 8'h0A;
      endcase
   endfunction

   task automatic set_inputs(input int m, input int t, input int f, input int s);
      mode      = 1'(m);
      temp      = 6'(t);
      temp_frac = 4'(f);
      state     = 4'(s);
      for (int i = 0; i < 10; i++) exp_q.push_back(model_char(i, m, t, f, s));
   endtask

   task automatic pulse_start(input bit expect_accept);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (expect_accept) begin
         check("busy_after_start", busy, 1);
         check("tx_low_after_start", tx, 0);
      end
   endtask

   task automatic send(input int m, input int t, input int f, input int s);
      set_inputs(m, t, f, s);
      pulse_start(1'b1);
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (busy === 1'b1 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check("frame_ends_in_budget", busy, 0);
      @(posedge clk);
      #1;
   endtask

   // Activity monitors
   initial begin
      forever begin
         @(negedge clk);
         if (busy === 1'b1) busy_cycles++;
         if (tx !== 1'b1) tx_low_cycles++;
      end
   end

   // Mid-bit sampling receiver; popped expectation 0x100 flags an unexpected byte.
   initial begin
      bit         active;
      int         cnt;
      int         k;
      logic [7:0] sh;
      logic [8:0] e;
      active = 1'b0;
      cnt    = 0;
      sh     = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 1'b0;
         end else if (!active) begin
            if (tx === 1'b0) begin
               active = 1'b1;
               cnt    = 0;
            end
         end else begin
            cnt++;
            if (cnt == Div / 2) begin
               check("rx_start_bit", tx, 0);
            end else if (cnt > Div / 2 && (cnt - Div / 2) % Div == 0) begin
               k = (cnt - Div / 2) / Div;
               if (k <= 8) begin
                  sh[k-1] = tx;
               end else begin
                  check("rx_stop_bit", tx, 1);
                  rx_bytes++;
                  e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
                  check("rx_byte", {24'd0, sh}, {23'd0, e});
                  active = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: time limit reached, busy=%0b", busy);
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;

      // 1: reset and idle
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_busy", busy, 0);
      check("reset_tx", tx, 1);
      busy_cycles   = 0;
      tx_low_cycles = 0;
      repeat (50) @(posedge clk);
      #1;
      check("idle_busy_cycles", busy_cycles, 0);
      check("idle_tx_low_cycles", tx_low_cycles, 0);

      // 2: negative reading
      busy_cycles = 0;
      r0 = rx_bytes;
      send(1, 23, 4, 2);
      wait_idle(1100);
      check("t2_busy_len", busy_cycles, 100 * Div);
      check("t2_rx_count", rx_bytes - r0, 10);
      check("t2_queue_empty", exp_q.size(), 0);

      // 3: frac clamp, leading zero, hex state
      busy_cycles = 0;
      r0 = rx_bytes;
      send(0, 5, 12, 11);
      wait_idle(1100);
      check("t3_busy_len", busy_cycles, 100 * Div);
      check("t3_rx_count", rx_bytes - r0, 10);
      check("t3_queue_empty", exp_q.size(), 0);

      // 4: input change and start ignored mid-frame
      busy_cycles = 0;
      r0 = rx_bytes;
      send(0, 47, 7, 15);
      repeat (4 * 10 * Div + 15) @(posedge clk);
      #1;
      temp = 6'd63;
      mode = 1'b1;
      pulse_start(1'b0);
      check("t4_still_busy", busy, 1);
      wait_idle(1100);
      check("t4_busy_len", busy_cycles, 100 * Div);
      check("t4_rx_count", rx_bytes - r0, 10);
      check("t4_queue_empty", exp_q.size(), 0);
      repeat (50) @(posedge clk);
      #1;
      check("t4_not_queued", busy, 0);
      check("t4_no_second_frame", busy_cycles, 100 * Div);

      // 5: back-to-back frames
      busy_cycles = 0;
      r0 = rx_bytes;
      send(1, 9, 0, 10);
      repeat (100 * Div - 1) @(posedge clk);
      #1;
      set_inputs(0, 60, 9, 3);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("t5_busy_held", busy, 1);
      check("t5_no_gap_tx", tx, 0);
      wait_idle(1100);
      check("t5_busy_len", busy_cycles, 200 * Div);
      check("t5_rx_count", rx_bytes - r0, 20);
      check("t5_queue_empty", exp_q.size(), 0);

      // 6: asynchronous reset mid-frame
      send(0, 31, 6, 13);
      repeat (6 * 10 * Div + 25) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t6_async_tx", tx, 1);
      check("t6_async_busy", busy, 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      busy_cycles   = 0;
      tx_low_cycles = 0;
      repeat (50) @(posedge clk);
      #1;
      check("t6_idle_busy", busy_cycles, 0);
      check("t6_idle_tx", tx_low_cycles, 0);
      busy_cycles = 0;
      r0 = rx_bytes;
      send(1, 0, 9, 0);
      wait_idle(1100);
      check("t6_busy_len", busy_cycles, 100 * Div);
      check("t6_rx_count", rx_bytes - r0, 10);
      check("t6_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/temp_report_tx.md
# temp_report_tx

- Serial reporter that formats a temperature reading and monitor state as a fixed 10-character ASCII line and shifts it out over an 8N1 UART.
- It is the outbound counterpart of the local display path: it takes the same `mode`/`temp`/`temp_frac`/`state` signals that feed the seven-segment mux and sends them to a host PC.
- It sits beside `monitor` in the top level, clocked from CLOCK_50.
- The 1 Hz tick is supplied to it as a `start` pulse, not used as a clock.

## Interface
Parameters:
- `CLK_HZ`, 50000000: input clock frequency.
- `BAUD`, 115200: line rate.
- `BAUD_DIV`, default CLK_HZ/BAUD rounded to nearest (434): clocks per bit, minimum 2.

Ports (all synchronous to `clk`):
- `clk` input 1: system clock (CLOCK_50).
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle request to send a report.
- `mode` input 1: 1 = negative temperature.
- `temp` input 6: integer part, 0–63.
- `temp_frac` input 4: tenths, 0–9; values above 9 are sent as 9.
- `state` input 4: monitor state code.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high while a frame is in progress.

## Operation
- Line format, 10 bytes, sent in this order:
  - sign: `-` (0x2D) if `mode`, else space (0x20)
  - tens digit: 0x30 + temp/10
  - ones digit: 0x30 + temp%10
  - `.` (0x2E)
  - frac digit: 0x30 + clamped frac
  - space (0x20)
  - `S` (0x53)
  - state hex digit: `0`–`9`, then `A`–`F` (0x41–0x46)
  - CR (0x0D)
  - LF (0x0A)
- Leading tens zero is sent as `0`; no suppression.
- Inputs are snapshotted into registers on the accepted `start` cycle. Later input changes do not affect the frame in flight.
- `start` while `busy` = 1 is ignored. It is not queued.
- Each byte is 8N1: start bit 0, data LSB first, one stop bit 1.
- Byte k+1's start bit immediately follows byte k's stop bit, with no idle gap.
- Top FSM states:
  - IDLE: `busy` = 0, `tx` = 1. Go to LOAD on `start`.
  - LOAD: select byte index 0..9 and hand it to the byte shifter. Go to SEND.
  - SEND: wait for the shifter's done signal. If index = 9, go to IDLE; else increment index and go to LOAD. LOAD is merged into the done cycle so that there is no gap.
- Byte shifter states: START, DATA (bits 0–7), STOP. Each state lasts BAUD_DIV clocks, counted by a baud counter that reloads at every bit boundary.
- BCD arithmetic: temp/10 and temp%10 use 6-bit inputs and 4-bit outputs. Either combinational or the existing `bin_2_bcd` is acceptable.

## Timing
- Reset values: `tx` = 1, `busy` = 0, FSM = IDLE, counters = 0.
- Reset asserted mid-frame: `tx` goes to 1 and `busy` to 0 asynchronously. The partial frame is abandoned and nothing resumes after release.
- `start` sampled high at edge N (IDLE): `busy` = 1 and `tx` = 0 from edge N+1.
- Every bit lasts exactly BAUD_DIV clocks.
- Frame length is 100×BAUD_DIV clocks from edge N+1. `busy` falls at the edge that ends the final stop bit, with `tx` = 1.
- A new `start` is accepted in the same cycle `busy` falls. The next frame then begins with no gap.
- `start` asserted for several cycles: only the first cycle starts a frame; the rest are ignored while busy. The remaining high cycles after the frame ends restart it, so the driver must pulse.

## Structure
- Shared constants go in `constants.h`: the ASCII codes (`ASCII_SPACE`, `ASCII_MINUS`, `ASCII_DOT`, `ASCII_S`, `ASCII_CR`, `ASCII_LF`, `ASCII_0`, `ASCII_A`).
- The existing `STATE_*` codes are reused unchanged.
- One sub-module, `uart_tx_byte`:
  - Parameter: BAUD_DIV.
  - Ports: clk, rst_n, `load`, `data[7:0]`, `tx`, `done` (one-cycle pulse at the end of the stop bit).
- `temp_report_tx` holds the snapshot registers, byte index, and character mux.

## Test plan
Sim uses BAUD_DIV = 10; a bench UART receiver samples at mid-bit.
1. Reset, then idle 50 cycles → `tx` = 1 and `busy` = 0 throughout.
2. `mode` = 1, `temp` = 23, `frac` = 4, `state` = 2, pulse `start` → bytes 2D 32 33 2E 34 20 53 32 0D 0A. `busy` is high for exactly 1000 cycles, and `tx` falls the cycle after `start`.
3. `mode` = 0, `temp` = 5, `frac` = 12, `state` = 11 → bytes 20 30 35 2E 39 20 53 42 0D 0A (frac clamped, tens `0`, state `B`).
4. Change `temp` to 63 mid-frame and pulse `start` again at byte 4 → frame unchanged, second `start` ignored, and exactly one frame received.
5. Pulse `start` in the cycle `busy` falls → second frame starts immediately, 2000 total busy cycles, no idle bit between frames.
6. Assert `rst_n` = 0 during byte 6 → `tx` = 1 and `busy` = 0 without waiting for a clock edge. After release, stays idle until the next `start`, then sends a complete correct frame.
